// File: rtl/seq_gate_pkg.sv
// seq_gate_pkg: shared state encoding and word-width helper for the
// sequenced gating controller (seq_gate_controller and its sub-module).
package seq_gate_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOCK = 2'd2
    } state_t;

    // Width of one pdQp fixed-point channel word.
    function automatic int word_w(input int pd, input int p);
        return pd + p;
    endfunction

endpackage

// File: rtl/seq_gate_busy_detect.sv
// seq_gate_busy_detect: flags pending work when the selected channel(s) hold a
// non-zero word and the consumer is not currently acknowledging.
// BUSY_ANY = 0 looks at channel 0 only; BUSY_ANY = 1 looks at every channel.
module seq_gate_busy_detect #(
    parameter int WORD_W   = 34,
    parameter int NCH      = 3,
    parameter int BUSY_ANY = 0
) (
    input  logic [NCH*WORD_W-1:0] i_data,
    input  logic                  valid,
    output logic                  busy
);

    logic [NCH-1:0] nz_s;
    logic           sel_s;

    for (genvar k = 0; k < NCH; k++) begin : g_nz
        assign nz_s[k] = |i_data[k*WORD_W +: WORD_W];
    end

    // Pick the busy source and mask it while the consumer acknowledges.
    always_comb begin
        sel_s = 1'b0;
        if (BUSY_ANY != 0) begin
            sel_s = |nz_s;
        end else begin
            sel_s = nz_s[0];
        end
        busy = sel_s & ~valid;
    end

endmodule

// File: rtl/seq_gate_controller.sv
// seq_gate_controller: gates NCH fixed-point channel words downstream for a
// programmable burst (cfg_len, 0 -> CNT_MAX), then locks until valid.
// Optional LOCK timeout is built only when SEQ_GATE_TIMEOUT_EN is defined;
// otherwise LOCK waits indefinitely and timeout is tied low.
module seq_gate_controller
    import seq_gate_pkg::*;
#(
    parameter int PD       = 12,
    parameter int P        = 22,
    parameter int NCH      = 3,
    parameter int CNT_MAX  = 6,
    parameter int CNT_W    = 3,
    parameter int BUSY_ANY = 0,
    parameter int TIMEOUT  = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NCH*word_w(PD,P)-1:0]   i_data,
    input  logic                          valid,
    input  logic [CNT_W-1:0]              cfg_len,
    output logic [NCH*word_w(PD,P)-1:0]   o_data,
    output logic [CNT_W-1:0]              cntr,
    output logic                          busy,
    output logic                          done,
    output logic                          locked,
    output logic                          timeout
);

    localparam int              WORD_W    = word_w(PD, P);
    localparam logic [CNT_W-1:0] CNT_MAX_C = CNT_W'(CNT_MAX);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cntr_r, cntr_s;
    logic [CNT_W-1:0] len_r, len_s;
    logic             done_r, done_s;
    logic             locked_r, locked_s;
    logic             busy_s;

`ifdef SEQ_GATE_TIMEOUT_EN
    localparam int          TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] tcnt_r, tcnt_s;
    logic            timeout_r, timeout_s;
`endif

    seq_gate_busy_detect #(
        .WORD_W   (WORD_W),
        .NCH      (NCH),
        .BUSY_ANY (BUSY_ANY)
    ) u_busy (
        .i_data (i_data),
        .valid  (valid),
        .busy   (busy_s)
    );

    assign busy   = busy_s;
    assign cntr   = cntr_r;
    assign done   = done_r;
    assign locked = locked_r;

    // Pass channel words straight through only while a burst is running.
    always_comb begin
        if (state_r == RUN) begin
            o_data = i_data;
        end else begin
            o_data = '0;
        end
    end

    // Next-state, burst counter, length capture and pulse generation.
    always_comb begin
        state_s   = state_r;
        cntr_s    = cntr_r;
        len_s     = len_r;
        done_s    = 1'b0;
`ifdef SEQ_GATE_TIMEOUT_EN
        tcnt_s    = tcnt_r;
        timeout_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                cntr_s = {CNT_W{1'b0}};
                if (busy_s) begin
                    state_s = RUN;
                    cntr_s  = CNT_W'(1);
                    if (cfg_len == {CNT_W{1'b0}}) begin
                        len_s = CNT_MAX_C;
                    end else begin
                        len_s = cfg_len;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // Terminal count wins over busy; valid only matters here.
                if (cntr_r == len_r) begin
                    cntr_s = {CNT_W{1'b0}};
                    done_s = 1'b1;
                    if (valid) begin
                        state_s = IDLE;
                    end else begin
                        state_s = LOCK;
`ifdef SEQ_GATE_TIMEOUT_EN
                        tcnt_s  = {TO_W{1'b0}};
`endif
                    end
                end else if (busy_s) begin
                    cntr_s = cntr_r + CNT_W'(1);
                end else begin
                    cntr_s = cntr_r;
                end
            end
            LOCK: begin
                cntr_s = {CNT_W{1'b0}};
                if (valid) begin
                    state_s = IDLE;
                end else begin
`ifdef SEQ_GATE_TIMEOUT_EN
                    if (tcnt_r == TO_LAST) begin
                        state_s   = IDLE;
                        timeout_s = 1'b1;
                    end else begin
                        tcnt_s    = tcnt_r + TO_W'(1);
                    end
`else
                    state_s = LOCK;
`endif
                end
            end
            default: begin
                state_s = IDLE;
                cntr_s  = {CNT_W{1'b0}};
            end
        endcase
        locked_s = (state_s == LOCK);
    end

    // State, counter, captured length and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cntr_r   <= {CNT_W{1'b0}};
            len_r    <= CNT_MAX_C;
            done_r   <= 1'b0;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cntr_r   <= cntr_s;
            len_r    <= len_s;
            done_r   <= done_s;
            locked_r <= locked_s;
        end
    end

`ifdef SEQ_GATE_TIMEOUT_EN
    // LOCK dwell counter and timeout pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_r    <= {TO_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            tcnt_r    <= tcnt_s;
            timeout_r <= timeout_s;
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

endmodule
